// File: rtl/fv_bank_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fv_bank_loader
//  Description : Streams words into NUM_BANKS SRAM banks of DEPTH entries
//                each, in bank-major order. A three-state FSM (IDLE/LOAD/DONE)
//                accepts a valid/ready stream and issues registered one-hot
//                bank writes one cycle after each accepted word.
//                Optional feature macro: FV_LOADER_CHECKSUM_EN
//                  defined   -> running XOR checksum of accepted words
//                  undefined -> checksum output tied to zero
//  Revision    : 1.0  initial release
// ============================================================================
module fv_bank_loader #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int NUM_BANKS = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [$clog2(NUM_BANKS)+$clog2(DEPTH)-1:0]    num_words,
    input  logic                                          abort,
    input  logic                                          in_valid,
    input  logic [DATA_W-1:0]                             in_data,
    output logic                                          in_ready,
    output logic [NUM_BANKS-1:0]                          wr_en,
    output logic [$clog2(DEPTH)-1:0]                      wr_addr,
    output logic [DATA_W-1:0]                             wr_data,
    output logic                                          busy,
    output logic                                          done,
    output logic [DATA_W-1:0]                             checksum
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_bw = $clog2(NUM_BANKS);
    // One extra bit so a full NUM_BANKS*DEPTH load can be counted without wrap
    localparam int c_cw = c_aw + c_bw + 1;

    localparam logic [c_cw-1:0] c_full = c_cw'(NUM_BANKS * DEPTH);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_cw-1:0]        r_count;
    logic [c_cw-1:0]        r_target;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_done;
    logic [NUM_BANKS-1:0]   r_wr_en;
    logic [c_aw-1:0]        r_wr_addr;
    logic [DATA_W-1:0]      r_wr_data;

    logic [c_cw-1:0]        w_target;
    logic [c_cw-1:0]        w_next_count;
    logic                   w_accept;
    logic [NUM_BANKS-1:0]   w_bank_sel;

    // Zero requests a load of every entry in every bank
    assign w_target     = (num_words == '0) ? c_full : {1'b0, num_words};
    assign w_next_count = r_count + c_one;
    // Abort blocks the handshake even though in_ready is high
    assign w_accept     = (r_state == S_LOAD) && in_valid && !abort;
    assign w_bank_sel   = NUM_BANKS'(1) << r_count[c_aw +: c_bw];

    // Control FSM with registered handshake, status and write-port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_target   <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= '0;
            case (r_state)
                S_IDLE: begin
                    // Start takes precedence over a coincident abort here
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_count    <= '0;
                        r_target   <= w_target;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state    <= S_DONE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (w_accept) begin
                        r_count   <= w_next_count;
                        r_wr_en   <= w_bank_sel;
                        r_wr_addr <= r_count[c_aw-1:0];
                        r_wr_data <= in_data;
                        // Last word: its write lands in the DONE cycle
                        if (w_next_count == r_target) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FV_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running XOR of accepted words; holds after DONE until the next start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum ^ in_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_fv_bank_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fv_bank_loader
//  Description : Self-checking bench for fv_bank_loader (default parameters).
//                Cycle table for short loads, abort and ignored inputs, plus
//                sequences for a full 4096-word load and reset mid-load.
//                Honours FV_LOADER_CHECKSUM_EN for checksum expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fv_bank_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] num_words;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int tests;
    int fails;

`ifdef FV_LOADER_CHECKSUM_EN
    localparam bit c_ck_en = 1'b1;
`else
    localparam bit c_ck_en = 1'b0;
`endif

    fv_bank_loader #(
        .DATA_W    (16),
        .DEPTH     (1024),
        .NUM_BANKS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for one cycle; expected outputs just after that edge
    typedef struct {
        logic        start;
        logic [11:0] nw;
        logic        abort;
        logic        valid;
        logic [15:0] data;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_wen;
        logic [9:0]  e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_ck;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic st, input logic [11:0] nw,
                                input logic ab, input logic v,
                                input logic [15:0] d, input logic rdy,
                                input logic bsy, input logic dn,
                                input logic [3:0] wen, input logic [9:0] a,
                                input logic [15:0] wd, input logic [15:0] ck);
        vec_t r;
        r.start = st;  r.nw = nw;    r.abort = ab;  r.valid = v;  r.data = d;
        r.e_rdy = rdy; r.e_busy = bsy; r.e_done = dn;
        r.e_wen = wen; r.e_addr = a; r.e_wdata = wd; r.e_ck = ck;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_vec(input int i, input vec_t v);
        @(negedge clk);
        start     = v.start;
        num_words = v.nw;
        abort     = v.abort;
        in_valid  = v.valid;
        in_data   = v.data;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v.e_rdy));
        chk($sformatf("v%0d busy", i),     32'(busy),     32'(v.e_busy));
        chk($sformatf("v%0d done", i),     32'(done),     32'(v.e_done));
        chk($sformatf("v%0d wr_en", i),    32'(wr_en),    32'(v.e_wen));
        chk($sformatf("v%0d checksum", i), 32'(checksum),
            c_ck_en ? 32'(v.e_ck) : 32'd0);
        if (v.e_wen != 4'd0) begin
            chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(v.e_addr));
            chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(v.e_wdata));
        end
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        num_words = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //          st nw     ab v  data      rdy bsy dn wen   addr wdata    ck
        // Five words with in_valid toggling; start while busy is ignored
        tbl[0]  = mk(1, 12'd5, 0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 12'd0, 0, 1, 16'h0010, 1, 1, 0, 4'h1, 0, 16'h0010, 16'h0010);
        tbl[2]  = mk(0, 12'd0, 0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 16'h0000, 16'h0010);
        tbl[3]  = mk(1, 12'd2, 0, 1, 16'h0011, 1, 1, 0, 4'h1, 1, 16'h0011, 16'h0001);
        tbl[4]  = mk(0, 12'd0, 0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 16'h0000, 16'h0001);
        tbl[5]  = mk(0, 12'd0, 0, 1, 16'h0012, 1, 1, 0, 4'h1, 2, 16'h0012, 16'h0013);
        tbl[6]  = mk(0, 12'd0, 0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 16'h0000, 16'h0013);
        tbl[7]  = mk(0, 12'd0, 0, 1, 16'h0013, 1, 1, 0, 4'h1, 3, 16'h0013, 16'h0000);
        tbl[8]  = mk(0, 12'd0, 0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 16'h0000, 16'h0000);
        tbl[9]  = mk(0, 12'd0, 0, 1, 16'h0014, 0, 0, 1, 4'h1, 4, 16'h0014, 16'h0014);
        // in_valid in DONE and in IDLE is ignored
        tbl[10] = mk(0, 12'd0, 0, 1, 16'h0055, 0, 0, 0, 4'h0, 0, 16'h0000, 16'h0014);
        tbl[11] = mk(0, 12'd0, 0, 1, 16'h0066, 0, 0, 0, 4'h0, 0, 16'h0000, 16'h0014);
        // start with abort in IDLE: start wins; checksum words
        tbl[12] = mk(1, 12'd3, 1, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 16'h0000, 16'h0000);
        tbl[13] = mk(0, 12'd0, 0, 1, 16'h1234, 1, 1, 0, 4'h1, 0, 16'h1234, 16'h1234);
        tbl[14] = mk(0, 12'd0, 0, 1, 16'h00FF, 1, 1, 0, 4'h1, 1, 16'h00FF, 16'h12CB);
        tbl[15] = mk(0, 12'd0, 0, 1, 16'hF000, 0, 0, 1, 4'h1, 2, 16'hF000, 16'hE2CB);
        tbl[16] = mk(0, 12'd0, 0, 0, 16'h0000, 0, 0, 0, 4'h0, 0, 16'h0000, 16'hE2CB);
        // abort coincident with the 3rd word
        tbl[17] = mk(1, 12'd10, 0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 16'h0000, 16'h0000);
        tbl[18] = mk(0, 12'd0, 0, 1, 16'h0AAA, 1, 1, 0, 4'h1, 0, 16'h0AAA, 16'h0AAA);
        tbl[19] = mk(0, 12'd0, 0, 1, 16'h0BBB, 1, 1, 0, 4'h1, 1, 16'h0BBB, 16'h0111);
        tbl[20] = mk(0, 12'd0, 1, 1, 16'h0CCC, 0, 0, 1, 4'h0, 0, 16'h0000, 16'h0111);
        tbl[21] = mk(0, 12'd0, 0, 1, 16'h0DDD, 0, 0, 0, 4'h0, 0, 16'h0000, 16'h0111);
        tbl[22] = mk(0, 12'd0, 0, 1, 16'h0EEE, 0, 0, 0, 4'h0, 0, 16'h0000, 16'h0111);

        // Reset state, checked while reset is still asserted
        idle_inputs();
        reset = 1'b0;
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst busy",     32'(busy),     32'd0);
        chk("rst done",     32'(done),     32'd0);
        chk("rst wr_en",    32'(wr_en),    32'd0);
        chk("rst wr_addr",  32'(wr_addr),  32'd0);
        chk("rst wr_data",  32'(wr_data),  32'd0);
        chk("rst checksum", 32'(checksum), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            apply_vec(i, tbl[i]);
        end

        // Full load: num_words = 0 means all 4096 entries
        @(negedge clk);
        idle_inputs();
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("full busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4096; k++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = 16'(k);
            @(posedge clk);
            #1;
            chk($sformatf("full wr_en k=%0d", k),   32'(wr_en),   32'(4'b0001 << (k / 1024)));
            chk($sformatf("full wr_addr k=%0d", k), 32'(wr_addr), 32'(k % 1024));
            chk($sformatf("full wr_data k=%0d", k), 32'(wr_data), 32'(k));
            chk($sformatf("full done k=%0d", k),    32'(done),    32'(k == 4095));
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("full after wr_en", 32'(wr_en), 32'd0);
        chk("full after done",  32'(done),  32'd0);

        // Reset asserted mid-load after 100 words
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'hA000 + k);
            @(negedge clk);
        end
        chk("mid wr_en",   32'(wr_en),   32'd1);
        chk("mid wr_addr", 32'(wr_addr), 32'd99);
        chk("mid busy",    32'(busy),    32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async in_ready", 32'(in_ready), 32'd0);
        chk("async busy",     32'(busy),     32'd0);
        chk("async done",     32'(done),     32'd0);
        chk("async wr_en",    32'(wr_en),    32'd0);
        chk("async wr_addr",  32'(wr_addr),  32'd0);
        chk("async wr_data",  32'(wr_data),  32'd0);
        chk("async checksum", 32'(checksum), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-rst wr_en c=%0d", c),    32'(wr_en),    32'd0);
            chk($sformatf("post-rst in_ready c=%0d", c), 32'(in_ready), 32'd0);
            chk($sformatf("post-rst busy c=%0d", c),     32'(busy),     32'd0);
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
